// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared constants, redirect encodings and fetch FSM states for MCS8.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W      = 14;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W        = $clog2(STACK_DEPTH);
  localparam int DAT_W       = 8;
  localparam int ENTRY_W     = DAT_W + ADDR_W;

  localparam logic [1:0] REDIR_OP_NONE = 2'b00;
  localparam logic [1:0] REDIR_OP_JMP  = 2'b01;
  localparam logic [1:0] REDIR_OP_CALL = 2'b10;
  localparam logic [1:0] REDIR_OP_RET  = 2'b11;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_fetch_fifo.sv
// ============================================================================
// Module : cpu_fetch_fifo
// Brief  : Synchronous first-word-fall-through FIFO; flush overrides push/pop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // The producer never pushes into a full FIFO, so no full guard here.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cpu_fetch_unit.sv
// ============================================================================
// Module : cpu_fetch_unit
// Brief  : MCS8 fetch front end: PC stack, ROM issue, prefetch FIFO, redirects.
//          Optional build macro CPU_FETCH_STKCHK_EN enables stack depth checking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  output logic [ADDR_W-1:0] I_ADDR_O,
  input  logic [DAT_W-1:0]  I_DAT_I,
  output logic [DAT_W-1:0]  IR_DAT_O,
  output logic [ADDR_W-1:0] IR_PC_O,
  output logic              IR_VALID_O,
  input  logic              IR_READY_I,
  input  logic              REDIR_I,
  input  logic [1:0]        REDIR_OP_I,
  input  logic [ADDR_W-1:0] REDIR_TGT_I,
  input  logic [ADDR_W-1:0] REDIR_RET_I,
  input  logic              HALT_I,
  input  logic              RESUME_I,
  output logic              STK_ERR_O
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];
  logic [SP_W-1:0]    idx_q, idx_d, idx_inc, idx_dec;
  logic               inflight_q;
  logic [ADDR_W-1:0]  infl_addr_q;
  fetch_state_e       state_q, state_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               redir, room, issue, push, pop;

  assign redir   = REDIR_I && (REDIR_OP_I != REDIR_OP_NONE);
  assign room    = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
  assign issue   = (state_q == S_RUN) && !redir && !HALT_I && room;
  assign push    = inflight_q && !redir;
  assign pop     = IR_VALID_O && IR_READY_I && !redir;
  assign idx_inc = idx_q + 1'b1;
  assign idx_dec = idx_q - 1'b1;

  always_comb begin
    stack_d = stack_q;
    idx_d   = idx_q;
    if (redir) begin
      case (REDIR_OP_I)
        REDIR_OP_JMP: stack_d[idx_q] = REDIR_TGT_I;
        REDIR_OP_CALL: begin
          stack_d[idx_q]   = REDIR_RET_I;
          stack_d[idx_inc] = REDIR_TGT_I;
          idx_d            = idx_inc;
        end
        REDIR_OP_RET: idx_d = idx_dec;
        default: ;
      endcase
    end else if (issue) begin
      stack_d[idx_q] = stack_q[idx_q] + 1'b1;
    end
  end

  // Redirect dominates every other transition; HALT_I dominates RESUME_I.
  always_comb begin
    state_d = state_q;
    if (redir) begin
      state_d = S_REDIR;
    end else begin
      case (state_q)
        S_RUN:   if (HALT_I) state_d = S_HALT;
        S_REDIR: state_d = S_RUN;
        S_HALT:  if (RESUME_I && !HALT_I) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      state_q     <= S_RUN;
    end else begin
      stack_q    <= stack_d;
      idx_q      <= idx_d;
      inflight_q <= issue;
      state_q    <= state_d;
      if (issue) begin
        infl_addr_q <= stack_q[idx_q];
      end
    end
  end

  cpu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .push_i  (push),
    .data_i  ({I_DAT_I, infl_addr_q}),
    .pop_i   (pop),
    .flush_i (redir),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign I_ADDR_O   = stack_q[idx_q];
  assign IR_VALID_O = (fifo_count != '0);
  assign IR_DAT_O   = fifo_head[ENTRY_W-1:ADDR_W];
  assign IR_PC_O    = fifo_head[ADDR_W-1:0];

`ifdef CPU_FETCH_STKCHK_EN
  logic [SP_W-1:0] depth_q;
  logic            err_q;

  // Depth saturates; the stack itself still wraps silently.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (redir && (REDIR_OP_I == REDIR_OP_CALL)) begin
      if (depth_q == SP_W'(STACK_DEPTH - 1)) err_q <= 1'b1;
      else                                   depth_q <= depth_q + 1'b1;
    end else if (redir && (REDIR_OP_I == REDIR_OP_RET)) begin
      if (depth_q == '0) err_q <= 1'b1;
      else               depth_q <= depth_q - 1'b1;
    end
  end

  assign STK_ERR_O = err_q;
`else
  assign STK_ERR_O = 1'b0;
`endif

endmodule

`default_nettype wire
